// File: rtl/reg_ram_1rw_pkg.sv
// -----------------------------------------------------------------------------
// reg_ram_1rw_pkg
// Shared constants and helpers for the register-based single-port RAM.
// No ports: provides default geometry and a depth helper used by
// reg_ram_1rw and its instantiating cache arrays.
// -----------------------------------------------------------------------------
package reg_ram_1rw_pkg;

    // Default geometry: 16 entries of 32 bits.
    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_LG_DEPTH = 4;

    // Number of entries addressed by an lg_depth-bit index.
    function automatic int unsigned depth_of(input int unsigned lg_depth);
        return 32'd1 << lg_depth;
    endfunction

endpackage : reg_ram_1rw_pkg

// File: rtl/reg_ram_1rw.sv
// -----------------------------------------------------------------------------
// reg_ram_1rw
// Single-port, register-based synchronous RAM used as the storage primitive
// for the cache arrays (data, tag, valid, dirty). One shared address, one
// write port, one registered read port with one-cycle latency. A read that
// collides with a write to the same entry returns the old contents.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; clears rd_data, blocks writes,
//                 leaves the array contents untouched
//   addr     in   [LG_DEPTH-1:0] entry index shared by read and write
//   wr_data  in   [WIDTH-1:0]    write data
//   wr_en    in   write enable for entry addr
//   rd_data  out  [WIDTH-1:0]    registered read data (mem[addr] of last edge)
// -----------------------------------------------------------------------------
module reg_ram_1rw
    import reg_ram_1rw_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned LG_DEPTH = DEFAULT_LG_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LG_DEPTH-1:0] addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                wr_en,
    output logic [WIDTH-1:0]    rd_data
);

    localparam int unsigned DEPTH = depth_of(LG_DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             mem_we;

    // Next-state for the read register and the array write strobe. The read
    // uses the array value before this edge's write lands, which gives the
    // read-first collision behaviour without any bypass logic.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional default first so
        // no path leaves it unassigned and no latch can be inferred.
        rd_data_d = '0;
        mem_we    = 1'b0;
        if (!reset) begin
            rd_data_d = mem_q[addr];
            mem_we    = wr_en;
        end
    end

    // NOTE: the array has no reset branch on purpose; clients initialise it by
    // walking every index, and leaving it unreset keeps it mappable to LUTRAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

`ifndef SYNTHESIS
    // An unknown address on a write would corrupt an unpredictable entry.
    a_wr_addr_known : assert property (
        @(posedge clk) disable iff (reset) wr_en |-> !$isunknown(addr)
    );
`endif

endmodule : reg_ram_1rw

// File: tb/tb_reg_ram_1rw.sv
// -----------------------------------------------------------------------------
// tb_reg_ram_1rw
// Drives three instances of reg_ram_1rw in lock-step from one stimulus stream:
//   u_w8   : WIDTH=8,   LG_DEPTH=4
//   u_w1   : WIDTH=1,   LG_DEPTH=2 (uses addr[1:0], wr_data[0])
//   u_w128 : WIDTH=128, LG_DEPTH=4
// A reference model (plain arrays, read-before-write) produces the expected
// read data for each edge and pushes it into a queue; a monitor pops one entry
// per clock and compares it against all three instances.
// -----------------------------------------------------------------------------
module tb_reg_ram_1rw;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   addr = '0;
    logic [127:0] wr_data = '0;
    logic         wr_en = 1'b0;

    logic [7:0]   rd_w8;
    logic         rd_w1;
    logic [127:0] rd_w128;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    reg_ram_1rw #(.WIDTH(8), .LG_DEPTH(4)) u_w8 (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_data (wr_data[7:0]),
        .wr_en   (wr_en),
        .rd_data (rd_w8)
    );

    reg_ram_1rw #(.WIDTH(1), .LG_DEPTH(2)) u_w1 (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr[1:0]),
        .wr_data (wr_data[0]),
        .wr_en   (wr_en),
        .rd_data (rd_w1)
    );

    reg_ram_1rw #(.WIDTH(128), .LG_DEPTH(4)) u_w128 (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_data (rd_w128)
    );

    // ---------------------------------------------------------------- model
    // Index 0: W8, 1: W1, 2: W128.
    typedef struct packed {
        logic [2:0]         known;     // expected value defined for instance i
        logic               not_aa;    // W8 must not read back the blocked 0xAA
        logic [2:0][127:0]  exp;
    } exp_t;

    exp_t          sb_q[$];
    logic [127:0]  model_mem [3][16];
    bit            written   [3][16];
    int unsigned   widths    [3] = '{8, 1, 128};
    int unsigned   depths    [3] = '{16, 4, 16};

    function automatic logic [127:0] width_mask(input int unsigned w);
        logic [127:0] one;
        one = 128'd1;
        return (one << w) - one;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus. Inputs change on the falling edge; after the
    // rising edge the model computes what rd_data must now hold (old contents
    // at addr, or zero under reset) and then applies the write.
    task automatic cycle(input logic r, input logic we, input logic [3:0] a,
                         input logic [127:0] d, input logic forbid_aa = 1'b0);
        exp_t        e;
        int unsigned ai;
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        e = '0;
        e.not_aa = forbid_aa;
        for (int i = 0; i < 3; i++) begin
            ai = a % depths[i];
            e.known[i] = r || written[i][ai];
            e.exp[i]   = r ? 128'd0 : model_mem[i][ai];
        end
        for (int i = 0; i < 3; i++) begin
            ai = a % depths[i];
            if (!r && we) begin
                model_mem[i][ai] = d & width_mask(widths[i]);
                written[i][ai]   = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    // -------------------------------------------------------------- monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.known[0]) check("w8 rd_data", {120'd0, rd_w8}, e.exp[0]);
                if (e.known[1]) check("w1 rd_data", {127'd0, rd_w1}, e.exp[1]);
                if (e.known[2]) check("w128 rd_data", rd_w128, e.exp[2]);
                if (e.not_aa) begin
                    checks++;
                    if (rd_w8 === 8'hAA) begin
                        errors++;
                        $display("FAIL w8 write during reset: got %h, required not aa", rd_w8);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    initial begin : stim
        logic [127:0] rnd;

        // Reset held two cycles while a write to addr 3 is attempted.
        cycle(1'b1, 1'b1, 4'd3, 128'hAA);
        cycle(1'b1, 1'b1, 4'd3, 128'hAA);
        cycle(1'b0, 1'b0, 4'd3, 128'h0, 1'b1);

        // Write then read: data visible one cycle after addr is presented.
        cycle(1'b0, 1'b1, 4'd5, 128'h3C);
        cycle(1'b0, 1'b0, 4'd5, 128'h0);
        cycle(1'b0, 1'b0, 4'd5, 128'h0);

        // Read-first collision on addr 2.
        cycle(1'b0, 1'b1, 4'd2, 128'h11);
        cycle(1'b0, 1'b1, 4'd2, 128'h22);
        cycle(1'b0, 1'b0, 4'd2, 128'h0);

        // Full sweep including index 15, read back in reverse.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'(i), 128'(i ^ 'h5A));
        for (int i = 15; i >= 0; i--) cycle(1'b0, 1'b0, 4'(i), 128'h0);
        cycle(1'b0, 1'b0, 4'd0, 128'h0);

        // Reset mid-operation: the entry addressed under reset keeps its value.
        cycle(1'b0, 1'b1, 4'd7, 128'h99);
        cycle(1'b1, 1'b1, 4'd7, 128'h00);
        cycle(1'b0, 1'b0, 4'd7, 128'h0);
        cycle(1'b0, 1'b0, 4'd7, 128'h0);

        // Narrow toggles: each W1 entry set to 1 then back to 0.
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 4'(a), 128'h1);
            cycle(1'b0, 1'b0, 4'(a), 128'h0);
            cycle(1'b0, 1'b1, 4'(a), 128'h0);
            cycle(1'b0, 1'b0, 4'(a), 128'h0);
        end
        cycle(1'b0, 1'b0, 4'd0, 128'h0);

        // Wide patterns on W128.
        cycle(1'b0, 1'b1, 4'd9, {128{1'b1}});
        cycle(1'b0, 1'b0, 4'd9, 128'h0);
        cycle(1'b0, 1'b1, 4'd9, {4{32'hDEADBEEF}});
        cycle(1'b0, 1'b0, 4'd9, 128'h0);
        cycle(1'b0, 1'b1, 4'd15, 128'hDEADBEEF);
        cycle(1'b0, 1'b0, 4'd15, 128'h0);
        cycle(1'b0, 1'b0, 4'd15, 128'h0);

        // Randomised traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            cycle($urandom_range(39, 0) == 0, $urandom_range(1, 0) == 1,
                  4'($urandom_range(15, 0)), rnd);
        end

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_ram_1rw
